// File: rtl/painterengine_gpu_pkg.sv
// painterengine_gpu_pkg: FSM state codes, o_wire_state field offsets and pixel-size codes
// shared by the frame fetcher and its block calculator.
package painterengine_gpu_pkg;
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CALC       = 3'd1,
        ST_WAIT_SPACE = 3'd2,
        ST_STREAM     = 3'd3,
        ST_RETRY      = 3'd4,
        ST_CHECK      = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERROR      = 3'd7
    } fetch_state_t;
    typedef enum logic [1:0] {PIX_1B = 2'd0, PIX_2B = 2'd1, PIX_4B = 2'd2} pixel_size_t;
    localparam int STATE_FSM_LSB   = 0;
    localparam int STATE_FD_BIT    = 8;
    localparam int STATE_ERROR_BIT = 9;
    localparam int STATE_BUSY_BIT  = 10;
    localparam int STATE_YDONE_BIT = 11;
    localparam int STATE_RETRY_LSB = 24;
    // Code 3 has no wider pixel behind it; fold it onto 4-byte pixels.
    function automatic logic [1:0] norm_pbl2(input logic [1:0] p);
        return (p == 2'd3) ? 2'(PIX_4B) : p;
    endfunction
endpackage

// File: rtl/painterengine_gpu_block_calc.sv
// painterengine_gpu_block_calc: combinational size/address of the next reader block
// starting at pixel x of the current line.
module painterengine_gpu_block_calc #(
    parameter int PARAM_BLOCK_PIXELS = 64
) (
    input  logic [15:0] x,
    input  logic [15:0] width,
    input  logic [31:0] line_base,
    input  logic [1:0]  pbl2,
    output logic [15:0] len_px,
    output logic [31:0] address,
    output logic [31:0] length
);
    localparam logic [15:0] BLOCK = 16'(PARAM_BLOCK_PIXELS);
    logic [15:0] remain;
    assign remain  = width - x;
    assign len_px  = (remain < BLOCK) ? remain : BLOCK;
    assign address = line_base + (32'(x) << pbl2);
    assign length  = 32'(len_px) << pbl2;
endmodule

// File: rtl/painterengine_gpu_frame_fetcher.sv
// painterengine_gpu_frame_fetcher: walks a clipped window of a pitched framebuffer in blocks for the DMA reader.
// Optional double buffering with PAINTERENGINE_GPU_FETCH_DOUBLE_BUFFER_EN.
module painterengine_gpu_frame_fetcher
    import painterengine_gpu_pkg::*;
#(
    parameter int PARAM_BLOCK_PIXELS = 64,
    parameter int PARAM_COUNT_W      = 8,
    parameter int PARAM_MAX_RETRY    = 3
) (
    input  logic                     i_wire_clock,
    input  logic                     i_wire_reset,
    input  logic                     i_wire_start,
    input  logic                     i_wire_abort,
    input  logic                     i_wire_continuous,
    input  logic [31:0]              i_wire_image_address,
    input  logic [15:0]              i_wire_image_stride,
    input  logic [15:0]              i_wire_clip_width,
    input  logic [15:0]              i_wire_clip_height,
    input  logic [1:0]               i_wire_pixel_bytes_log2,
    input  logic [PARAM_COUNT_W-1:0] i_wire_fifo_free_count,
    input  logic [31:0]              i_wire_back_address,
    input  logic                     i_wire_swap_request,
    output logic                     o_wire_swap_ack,
    output logic [31:0]              o_wire_reader_address,
    output logic [31:0]              o_wire_reader_length,
    output logic                     o_wire_reader_resetn,
    input  logic                     i_wire_reader_done,
    input  logic                     i_wire_reader_error,
    output logic                     o_wire_frame_done,
    output logic                     o_wire_busy,
    output logic [31:0]              o_wire_state
);
    localparam logic [7:0] MAX_RETRY = 8'(PARAM_MAX_RETRY);
    fetch_state_t st, st_n;
    logic [15:0] x, y, width_l, height_l, len_px, calc_len_px, stride_l, y_inc;
    logic [31:0] line_base, base_l, calc_addr, calc_len, frame_base;
    logic [7:0]  retry_cnt;
    logic [1:0]  pbl2_l;
    logic        fd_sticky, y_done, start_ok, empty, line_end, frame_end, space_ok, take;
    assign start_ok  = i_wire_start && (st == ST_IDLE || st == ST_DONE);
    assign empty     = (i_wire_clip_width == 16'd0) || (i_wire_clip_height == 16'd0);
    assign y_inc     = y + 16'd1;
    assign line_end  = x == width_l;
    assign frame_end = line_end && (y_inc == height_l);
    assign space_ok  = 32'({i_wire_fifo_free_count, 2'b00}) >= o_wire_reader_length;
`ifdef PAINTERENGINE_GPU_FETCH_DOUBLE_BUFFER_EN
    logic front, pend;
    assign take       = (pend | i_wire_swap_request) & ~i_wire_abort & (start_ok | ((st == ST_CHECK) & frame_end));
    assign frame_base = (front ^ take) ? i_wire_back_address : i_wire_image_address;
    always_ff @(posedge i_wire_clock or posedge i_wire_reset)
        if (i_wire_reset) begin
            front <= 1'b0;
            pend  <= 1'b0;
        end else begin
            front <= front ^ take;
            pend  <= (pend | i_wire_swap_request) & ~take;
        end
`else
    logic unused_swap;
    assign unused_swap = ^{i_wire_back_address, i_wire_swap_request};
    assign take        = 1'b0;
    assign frame_base  = i_wire_image_address;
`endif
    painterengine_gpu_block_calc #(.PARAM_BLOCK_PIXELS(PARAM_BLOCK_PIXELS)) u_calc (
        .x(x), .width(width_l), .line_base(line_base), .pbl2(pbl2_l),
        .len_px(calc_len_px), .address(calc_addr), .length(calc_len)
    );
    always_ff @(posedge i_wire_clock or posedge i_wire_reset)
        if (i_wire_reset) st <= ST_IDLE;
        else st <= st_n;
    always_comb begin
        st_n = st;
        case (st)
            ST_IDLE, ST_DONE: st_n = start_ok ? (empty ? ST_DONE : ST_CALC) : st;
            ST_CALC:          st_n = ST_WAIT_SPACE;
            ST_WAIT_SPACE:    st_n = space_ok ? ST_STREAM : st;
            // error outranks a coincident done
            ST_STREAM:        st_n = i_wire_reader_error ? ((retry_cnt < MAX_RETRY) ? ST_RETRY : ST_ERROR)
                                   : (i_wire_reader_done ? ST_CHECK : st);
            ST_RETRY:         st_n = ST_STREAM;
            ST_CHECK:         st_n = (frame_end && !i_wire_continuous) ? ST_DONE : ST_CALC;
            default:          st_n = st;
        endcase
        if (i_wire_abort) st_n = ST_IDLE;
    end
    always_ff @(posedge i_wire_clock or posedge i_wire_reset)
        if (i_wire_reset) begin
            x <= '0; y <= '0; width_l <= '0; height_l <= '0; stride_l <= '0; pbl2_l <= '0;
            line_base <= '0; base_l <= '0; len_px <= '0; retry_cnt <= '0;
            o_wire_reader_address <= '0; o_wire_reader_length <= '0;
            o_wire_frame_done <= 1'b0; o_wire_swap_ack <= 1'b0; fd_sticky <= 1'b0; y_done <= 1'b0;
        end else begin
            o_wire_frame_done <= 1'b0;
            o_wire_swap_ack   <= take;
            if (i_wire_abort) begin
                x <= '0; y <= '0; retry_cnt <= '0;
            end else if (start_ok) begin
                width_l <= i_wire_clip_width; height_l <= i_wire_clip_height; stride_l <= i_wire_image_stride;
                pbl2_l <= norm_pbl2(i_wire_pixel_bytes_log2);
                base_l <= frame_base; line_base <= frame_base;
                x <= '0; y <= '0; retry_cnt <= '0;
                o_wire_frame_done <= empty; fd_sticky <= empty; y_done <= 1'b0;
            end else begin
                case (st)
                    ST_CALC: begin
                        o_wire_reader_address <= calc_addr;
                        o_wire_reader_length  <= calc_len;
                        len_px                <= calc_len_px;
                    end
                    ST_STREAM: if (!i_wire_reader_error && i_wire_reader_done) begin
                        x <= x + len_px;
                        retry_cnt <= '0;
                    end
                    ST_RETRY: retry_cnt <= retry_cnt + 8'd1;
                    ST_CHECK: if (line_end) begin
                        x <= '0;
                        y <= (frame_end && i_wire_continuous) ? '0 : y_inc;
                        line_base <= !frame_end ? line_base + 32'(stride_l) : (take ? frame_base : base_l);
                        if (frame_end) begin
                            base_l <= take ? frame_base : base_l;
                            o_wire_frame_done <= 1'b1;
                            fd_sticky <= 1'b1;
                            y_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    assign o_wire_reader_resetn = st == ST_STREAM;
    assign o_wire_busy = !(st == ST_IDLE || st == ST_DONE || st == ST_ERROR);
    always_comb begin
        o_wire_state = '0;
        o_wire_state[STATE_FSM_LSB +: 3]   = st;
        o_wire_state[STATE_FD_BIT]         = fd_sticky;
        o_wire_state[STATE_ERROR_BIT]      = st == ST_ERROR;
        o_wire_state[STATE_BUSY_BIT]       = o_wire_busy;
        o_wire_state[STATE_YDONE_BIT]      = y_done;
        o_wire_state[STATE_RETRY_LSB +: 8] = retry_cnt;
    end
endmodule

// File: tb/tb_painterengine_gpu_frame_fetcher.sv
// tb_painterengine_gpu_frame_fetcher: table of frame geometries against a request scoreboard,
// plus hand sequences for FIFO throttling, retry, error, abort, continuous mode and async reset.
module tb_painterengine_gpu_frame_fetcher;
    import painterengine_gpu_pkg::*;
    logic clk = 0, rst = 0, start = 0, abort = 0, cont = 0, swap_req = 0, rd_done = 0, rd_err = 0;
    logic [31:0] img = 0, back = 0;
    logic [15:0] stride = 0, cw = 0, ch = 0;
    logic [1:0]  pbl2 = 0;
    logic [7:0]  free = 8'd255;
    logic        swap_ack, resetn, frame_done, busy;
    logic [31:0] raddr, rlen, state;

    always #5 clk = ~clk;

    painterengine_gpu_frame_fetcher dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start), .i_wire_abort(abort),
        .i_wire_continuous(cont), .i_wire_image_address(img), .i_wire_image_stride(stride),
        .i_wire_clip_width(cw), .i_wire_clip_height(ch), .i_wire_pixel_bytes_log2(pbl2),
        .i_wire_fifo_free_count(free), .i_wire_back_address(back), .i_wire_swap_request(swap_req),
        .o_wire_swap_ack(swap_ack), .o_wire_reader_address(raddr), .o_wire_reader_length(rlen),
        .o_wire_reader_resetn(resetn), .i_wire_reader_done(rd_done), .i_wire_reader_error(rd_err),
        .o_wire_frame_done(frame_done), .o_wire_busy(busy), .o_wire_state(state)
    );

    typedef struct { logic [31:0] a; logic [31:0] l; } req_t;
    typedef struct {
        logic [31:0] base; logic [15:0] stride; logic [15:0] w; logic [15:0] h; logic [1:0] p;
        int blocks; logic [31:0] last_len;
    } vec_t;
    req_t q[$];
    vec_t v[7];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference walk of the window: one request per block, 64-pixel blocks.
    task automatic push_frame(input logic [31:0] b, input logic [15:0] s, input logic [15:0] w,
                              input logic [15:0] h, input logic [1:0] p);
        logic [31:0] lb = b;
        int sh = (p == 2'd3) ? 2 : int'(p);
        int wi = int'(w);
        int hi = int'(h);
        for (int yy = 0; yy < hi; yy++) begin
            for (int xx = 0; xx < wi; xx += 64) begin
                int n = (wi - xx < 64) ? wi - xx : 64;
                q.push_back('{lb + 32'(xx << sh), 32'(n << sh)});
            end
            lb = lb + 32'(s);
        end
    endtask

    task automatic launch(input logic [31:0] b, input logic [15:0] s, input logic [15:0] w,
                          input logic [15:0] h, input logic [1:0] p);
        img = b; stride = s; cw = w; ch = h; pbl2 = p; start = 1;
    endtask

    // Acts as the reader: answers every STREAM with done, checks requests against the scoreboard.
    task automatic serve(input string tag, input int exp_blocks, input logic [31:0] exp_last, output logic ack);
        int blocks = 0;
        int seen = 0;
        logic [31:0] last = 0;
        ack = 0;
        for (int c = 0; c < 3000 && seen == 0; c++) begin
            tick();
            start = 0; swap_req = 0; rd_done = 0;
            if (frame_done) begin
                seen = 1;
                ack = swap_ack;
            end else if (resetn) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s unexpected request: got addr %h len %h expected none", tag, raddr, rlen);
                    rd_done = 1;
                end else begin
                    req_t e = q.pop_front();
                    chk({tag, " addr"}, raddr, e.a);
                    chk({tag, " len"}, rlen, e.l);
                    last = rlen;
                    blocks++;
                    rd_done = 1;
                end
            end
        end
        if (seen == 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: got no frame_done expected frame_done", tag);
        end
        chk({tag, " blocks"}, 32'(blocks), 32'(exp_blocks));
        chk({tag, " leftover"}, 32'(q.size()), 32'd0);
        if (exp_blocks > 0) chk({tag, " last len"}, last, exp_last);
    endtask

    initial begin
        logic ack;
        int nerr, retries, seen;
        v[0] = '{32'h1000, 16'd256, 16'd64, 16'd2, 2'd2, 2, 32'd256};
        v[1] = '{32'h2000, 16'h400, 16'd100, 16'd1, 2'd1, 2, 32'd72};
        v[2] = '{32'h0, 16'd16, 16'd3, 16'd3, 2'd0, 3, 32'd3};
        v[3] = '{32'h100, 16'h200, 16'd70, 16'd1, 2'd3, 2, 32'd24};
        v[4] = '{32'hFFFF_FF00, 16'h100, 16'd64, 16'd2, 2'd2, 2, 32'd256};
        v[5] = '{32'h3000, 16'd64, 16'd0, 16'd5, 2'd2, 0, 32'd0};
        v[6] = '{32'h3000, 16'd64, 16'd8, 16'd0, 2'd2, 0, 32'd0};

        #2 rst = 1;
        #1;
        chk("reset addr", raddr, 32'd0);
        chk("reset len", rlen, 32'd0);
        chk("reset resetn", 32'(resetn), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset swap_ack", 32'(swap_ack), 32'd0);
        chk("reset state", state, 32'd0);
        tick(); tick();
        rst = 0;

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            q.delete();
            push_frame(v[i].base, v[i].stride, v[i].w, v[i].h, v[i].p);
            launch(v[i].base, v[i].stride, v[i].w, v[i].h, v[i].p);
            serve(tag, v[i].blocks, v[i].last_len, ack);
            chk({tag, " state done"}, 32'(state[2:0]), 32'(ST_DONE));
            chk({tag, " busy"}, 32'(busy), 32'd0);
            chk({tag, " fd sticky"}, 32'(state[8]), 32'd1);
        end

        // FIFO throttle: 256-byte block needs 64 free words
        free = 8'd10;
        launch(32'h5000, 16'd256, 16'd64, 16'd1, 2'd2);
        tick(); start = 0;
        tick();
        chk("wait state", 32'(state[2:0]), 32'(ST_WAIT_SPACE));
        chk("wait resetn", 32'(resetn), 32'd0);
        chk("wait addr", raddr, 32'h5000);
        chk("wait len", rlen, 32'd256);
        tick();
        chk("wait hold", 32'(state[2:0]), 32'(ST_WAIT_SPACE));
        free = 8'd64;
        tick();
        chk("wait release", 32'(state[2:0]), 32'(ST_STREAM));
        chk("wait release resetn", 32'(resetn), 32'd1);
        rd_done = 1;
        tick(); rd_done = 0;
        tick();
        chk("wait frame_done", 32'(frame_done), 32'd1);
        free = 8'd255;

        // two errors then done
        launch(32'h6000, 16'd256, 16'd64, 16'd1, 2'd2);
        nerr = 0; retries = 0; seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            tick();
            start = 0; rd_done = 0; rd_err = 0;
            if (state[2:0] == ST_RETRY) begin
                retries++;
                chk("retry resetn", 32'(resetn), 32'd0);
                chk("retry addr", raddr, 32'h6000);
            end
            if (frame_done) seen = 1;
            else if (resetn) begin
                if (nerr < 2) begin rd_err = 1; nerr++; end
                else rd_done = 1;
            end
        end
        chk("retry pulses", 32'(retries), 32'd2);
        chk("retry frame_done", 32'(seen), 32'd1);

        // persistent errors exhaust the retry budget
        launch(32'h6000, 16'd256, 16'd64, 16'd1, 2'd2);
        nerr = 0;
        for (int c = 0; c < 100 && state[2:0] != ST_ERROR; c++) begin
            tick();
            start = 0; rd_err = 0;
            if (resetn) begin rd_err = 1; nerr++; end
        end
        rd_err = 0;
        chk("error count", 32'(nerr), 32'd4);
        chk("error state", 32'(state[2:0]), 32'(ST_ERROR));
        chk("error bit", 32'(state[9]), 32'd1);
        chk("error retry_cnt", 32'(state[31:24]), 32'd3);
        chk("error busy", 32'(busy), 32'd0);
        chk("error resetn", 32'(resetn), 32'd0);
        start = 1;
        tick(); start = 0;
        tick();
        chk("error sticky", 32'(state[2:0]), 32'(ST_ERROR));
        abort = 1;
        tick(); abort = 0;
        chk("error abort", 32'(state[2:0]), 32'(ST_IDLE));

        // done+error together counts as error, then abort mid-STREAM
        launch(32'h6000, 16'd256, 16'd64, 16'd1, 2'd2);
        for (int c = 0; c < 20 && !resetn; c++) begin
            tick();
            start = 0;
        end
        rd_done = 1; rd_err = 1;
        tick(); rd_done = 0; rd_err = 0;
        chk("both -> retry", 32'(state[2:0]), 32'(ST_RETRY));
        tick();
        chk("back to stream", 32'(resetn), 32'd1);
        abort = 1;
        tick(); abort = 0;
        chk("abort resetn", 32'(resetn), 32'd0);
        chk("abort state", 32'(state[2:0]), 32'(ST_IDLE));
        chk("abort busy", 32'(busy), 32'd0);

        // continuous looping with a swap request raised mid-frame
        cont = 1; back = 32'h9000;
        launch(32'h7000, 16'd256, 16'd64, 16'd1, 2'd2);
        q.delete();
        push_frame(32'h7000, 16'd256, 16'd64, 16'd1, 2'd2);
        tick(); start = 0;
        swap_req = 1;
        serve("cont1", 1, 32'd256, ack);
`ifdef PAINTERENGINE_GPU_FETCH_DOUBLE_BUFFER_EN
        chk("swap_ack with frame_done", 32'(ack), 32'd1);
        push_frame(32'h9000, 16'd256, 16'd64, 16'd1, 2'd2);
`else
        chk("swap_ack tied low", 32'(ack), 32'd0);
        push_frame(32'h7000, 16'd256, 16'd64, 16'd1, 2'd2);
`endif
        chk("cont restart busy", 32'(busy), 32'd1);
        cont = 0;
        serve("cont2", 1, 32'd256, ack);
        chk("cont stop", 32'(state[2:0]), 32'(ST_DONE));

        // async reset while the reader is running
        launch(32'h8000, 16'd256, 16'd64, 16'd1, 2'd2);
        for (int c = 0; c < 20 && !resetn; c++) begin
            tick();
            start = 0;
        end
        #2 rst = 1;
        #1;
        chk("async reset resetn", 32'(resetn), 32'd0);
        chk("async reset state", state, 32'd0);
        chk("async reset addr", raddr, 32'd0);
        tick();
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
